ro_sweep_scheduler: RTL and testbench

Sequences measurement windows across a bank of ring-oscillator edge counters for power side-channel capture.
- On start, it walks the enabled RO indices in ascending order. For each index it clears the counter, enables the RO for a programmed window, waits for counter settle, then captures the count.
- Each result is presented on a valid/ready stream.
- Sits between the RO bank/counters and the capture FIFO / host interface.

---
 rtl/ro_pkg.sv | 14 +
 rtl/ro_idx_pick.sv | 27 ++
 rtl/ro_sweep_scheduler.sv | 171 +++++++++++++++++
 tb/tb_ro_sweep_scheduler.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/ro_pkg.sv
// Shared types and constants for the ring-oscillator sweep scheduler.
package ro_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_WINDOW = 3'd2,
        ST_SETTLE = 3'd3,
        ST_OUTPUT = 3'd4
    } ro_sched_state_t;

    localparam int RO_SETTLE_CYCLES = 1;

endpackage

// File: rtl/ro_idx_pick.sv
// Combinational finder: lowest set bit of mask above base (or at base when incl=1).
module ro_idx_pick #(
    parameter int NUM_RO = 8,
    parameter int IDX_W  = $clog2(NUM_RO)
) (
    input  logic [NUM_RO-1:0] mask,
    input  logic [IDX_W-1:0]  base,
    input  logic              incl,
    output logic              found,
    output logic [IDX_W-1:0]  idx
);

    logic hit_s;

    // Scan high-to-low so the lowest qualifying bit is the one left standing.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        hit_s = 1'b0;
        for (int i = NUM_RO - 1; i >= 0; i--) begin
            hit_s = mask[i] && ((i > int'(base)) || (incl && (i == int'(base))));
            found = found | hit_s;
            idx   = hit_s ? IDX_W'(i) : idx;
        end
    end

endmodule

// File: rtl/ro_sweep_scheduler.sv
// Walks enabled ring oscillators in ascending order: clear, window, settle, report.
// Optional macro RO_SWEEP_ID_EN adds a sweep_id output counting completed sweeps.
module ro_sweep_scheduler
    import ro_pkg::*;
#(
    parameter int NUM_RO = 8,
    parameter int CNT_W  = 16,
    parameter int WIN_W  = 16,
    parameter int IDX_W  = $clog2(NUM_RO)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cont,
    input  logic [NUM_RO-1:0] ro_mask,
    input  logic [WIN_W-1:0]  win_len,
    input  logic [CNT_W-1:0]  ro_count,
    output logic [NUM_RO-1:0] ro_en,
    output logic              ro_clr,
    output logic              busy,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [CNT_W-1:0]  res_data,
    output logic [IDX_W-1:0]  res_idx,
    output logic              res_last,
`ifdef RO_SWEEP_ID_EN
    output logic [15:0]       sweep_id,
`endif
    output logic              done
);

    localparam logic [NUM_RO-1:0] EN_ONE  = {{(NUM_RO-1){1'b0}}, 1'b1};
    localparam logic [WIN_W-1:0]  WIN_ONE = {{(WIN_W-1){1'b0}}, 1'b1};

    ro_sched_state_t   state_r, state_s;
    logic [NUM_RO-1:0] mask_r, mask_s, pick_mask_s;
    logic              cont_r, cont_s;
    logic [WIN_W-1:0]  win_r, win_s, win_cnt_r, win_cnt_s;
    logic [IDX_W-1:0]  idx_r, idx_s;
    logic              done_s, capture_s;
    logic              first_found_s, next_found_s;
    logic [IDX_W-1:0]  first_idx_s, next_idx_s;

    // In IDLE the first pick looks at the live mask; afterwards at the latched one.
    assign pick_mask_s = (state_r == ST_IDLE) ? ro_mask : mask_r;

    ro_idx_pick #(.NUM_RO(NUM_RO), .IDX_W(IDX_W)) u_first_pick (
        .mask  (pick_mask_s),
        .base  ({IDX_W{1'b0}}),
        .incl  (1'b1),
        .found (first_found_s),
        .idx   (first_idx_s)
    );

    ro_idx_pick #(.NUM_RO(NUM_RO), .IDX_W(IDX_W)) u_next_pick (
        .mask  (mask_r),
        .base  (idx_r),
        .incl  (1'b0),
        .found (next_found_s),
        .idx   (next_idx_s)
    );

    // Next-state and latched-config logic for the sweep sequencer.
    always_comb begin
        state_s   = state_r;
        mask_s    = mask_r;
        cont_s    = cont_r;
        win_s     = win_r;
        win_cnt_s = win_cnt_r;
        idx_s     = idx_r;
        done_s    = 1'b0;
        capture_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start && first_found_s) begin
                    mask_s  = ro_mask;
                    cont_s  = cont;
                    win_s   = (win_len == {WIN_W{1'b0}}) ? WIN_ONE : win_len;
                    idx_s   = first_idx_s;
                    state_s = ST_CLEAR;
                end else if (start) begin
                    done_s  = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                win_cnt_s = win_r;
                state_s   = ST_WINDOW;
            end
            ST_WINDOW: begin
                if (win_cnt_r <= WIN_ONE) begin
                    state_s = ST_SETTLE;
                end else begin
                    win_cnt_s = win_cnt_r - WIN_ONE;
                end
            end
            ST_SETTLE: begin
                capture_s = 1'b1;
                state_s   = ST_OUTPUT;
            end
            ST_OUTPUT: begin
                if (res_valid && res_ready && next_found_s) begin
                    idx_s   = next_idx_s;
                    state_s = ST_CLEAR;
                end else if (res_valid && res_ready && cont_r) begin
                    done_s  = 1'b1;
                    idx_s   = first_idx_s;
                    state_s = ST_CLEAR;
                end else if (res_valid && res_ready) begin
                    done_s  = 1'b1;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_OUTPUT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, config and outputs; outputs are decoded from the next state so they are registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            mask_r    <= '0;
            cont_r    <= 1'b0;
            win_r     <= '0;
            win_cnt_r <= '0;
            idx_r     <= '0;
            ro_en     <= '0;
            ro_clr    <= 1'b0;
            busy      <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_idx   <= '0;
            res_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_r   <= state_s;
            mask_r    <= mask_s;
            cont_r    <= cont_s;
            win_r     <= win_s;
            win_cnt_r <= win_cnt_s;
            idx_r     <= idx_s;
            ro_en     <= (state_s == ST_WINDOW) ? (EN_ONE << idx_s) : {NUM_RO{1'b0}};
            ro_clr    <= (state_s == ST_CLEAR);
            busy      <= (state_s != ST_IDLE);
            res_valid <= (state_s == ST_OUTPUT);
            done      <= done_s;
            if (capture_s) begin
                res_data <= ro_count;
                res_idx  <= idx_r;
                res_last <= ~next_found_s;
            end
        end
    end

`ifdef RO_SWEEP_ID_EN
    // Sweep counter bumps with each done pulse, so it stays constant across a sweep's results.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sweep_id <= 16'd0;
        end else if (done_s) begin
            sweep_id <= sweep_id + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ro_sweep_scheduler.sv
// Self-checking bench for ro_sweep_scheduler: cycle-timestamp model plus directed and random sweeps.
module tb_ro_sweep_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, cont = 1'b0, res_ready = 1'b0;
    logic [7:0]  ro_mask = 8'h00;
    logic [15:0] win_len = 16'd0, ro_count = 16'd0;
    logic [7:0]  ro_en;
    logic        ro_clr, busy, res_valid, res_last, done;
    logic [15:0] res_data;
    logic [2:0]  res_idx;
`ifdef RO_SWEEP_ID_EN
    logic [15:0] sweep_id;
`endif

    ro_sweep_scheduler #(.NUM_RO(8), .CNT_W(16), .WIN_W(16), .IDX_W(3)) dut (
        .clk(clk), .rst(rst), .start(start), .cont(cont), .ro_mask(ro_mask),
        .win_len(win_len), .ro_count(ro_count), .ro_en(ro_en), .ro_clr(ro_clr),
        .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_idx(res_idx), .res_last(res_last),
`ifdef RO_SWEEP_ID_EN
        .sweep_id(sweep_id),
`endif
        .done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: the current sweep is a list of indices; each index's phases are cycle offsets from t_clr.
    int          k = 0;
    bit          m_active = 1'b0;
    int          m_list[$];
    int          m_pos = 0, m_len = 1, t_clr = 0, done_cyc = -1;
    bit          m_cont = 1'b0;
    logic [15:0] m_data = 16'd0;
    logic [15:0] sid = 16'd0;

    int          n_clr, n_done, n_busy, n_hs, n_en, n_last;
    logic [7:0]  s_en;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, k);
        end
    endtask

    task automatic clear_counts();
        n_clr = 0; n_done = 0; n_busy = 0; n_hs = 0; n_en = 0; n_last = 0;
    endtask

    task automatic step(input bit st, input bit ct, input logic [7:0] mk,
                        input logic [15:0] wl, input bit rdy);
        logic       e_clr, e_valid, e_done;
        logic [7:0] e_en, one;
        @(negedge clk);
        one     = 8'h01;
        e_en    = 8'h00;
        e_clr   = m_active && (k == t_clr);
        e_valid = m_active && (k >= t_clr + m_len + 2);
        e_done  = (k == done_cyc);
        if (m_active && (k >= t_clr + 1) && (k <= t_clr + m_len)) e_en = one << m_list[m_pos];
        if (e_done) sid = sid + 16'd1;
        chk("ro_clr", 32'(ro_clr), 32'(e_clr));
        chk("ro_en", 32'(ro_en), 32'(e_en));
        chk("busy", 32'(busy), 32'(m_active));
        chk("res_valid", 32'(res_valid), 32'(e_valid));
        chk("done", 32'(done), 32'(e_done));
        if (e_valid) begin
            chk("res_data", 32'(res_data), 32'(m_data));
            chk("res_idx", 32'(res_idx), 32'(m_list[m_pos]));
            chk("res_last", 32'(res_last), 32'(m_pos == m_list.size() - 1));
        end
`ifdef RO_SWEEP_ID_EN
        chk("sweep_id", 32'(sweep_id), 32'(sid));
`endif
        n_clr  += int'(ro_clr);
        n_done += int'(done);
        n_busy += int'(busy);
        n_en   += int'(ro_en != 8'h00);
        n_hs   += int'(res_valid && rdy);
        n_last += int'(res_valid && rdy && res_last);
        s_en    = ro_en;
        start = st; cont = ct; ro_mask = mk; win_len = wl; res_ready = rdy;
        ro_count = 16'($urandom);
        if (m_active && (k == t_clr + m_len + 1)) m_data = ro_count;
        if (e_valid && rdy) begin
            if (m_pos < m_list.size() - 1) begin
                m_pos++;
                t_clr = k + 1;
            end else begin
                done_cyc = k + 1;
                if (m_cont) begin
                    m_pos = 0;
                    t_clr = k + 1;
                end else begin
                    m_active = 1'b0;
                end
            end
        end else if (!m_active && st) begin
            if (mk != 8'h00) begin
                m_list.delete();
                for (int i = 0; i < 8; i++) if (mk[i]) m_list.push_back(i);
                m_len    = (wl == 16'd0) ? 1 : int'(wl);
                m_cont   = ct;
                m_pos    = 0;
                m_active = 1'b1;
                t_clr    = k + 1;
            end else begin
                done_cyc = k + 1;
            end
        end
        k++;
    endtask

    task automatic do_reset();
        rst = 1'b0; start = 1'b0; cont = 1'b0; res_ready = 1'b0;
        #1;
        chk("rst_ro_en", 32'(ro_en), 32'h0);
        chk("rst_ro_clr", 32'(ro_clr), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_res_valid", 32'(res_valid), 32'h0);
        chk("rst_res_data", 32'(res_data), 32'h0);
        chk("rst_res_idx", 32'(res_idx), 32'h0);
        chk("rst_res_last", 32'(res_last), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
`ifdef RO_SWEEP_ID_EN
        chk("rst_sweep_id", 32'(sweep_id), 32'h0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        m_active = 1'b0; done_cyc = -1; sid = 16'd0;
    endtask

    initial begin
        #1;
        do_reset();

        // Two-index sweep with constant ready.
        clear_counts();
        step(1'b1, 1'b0, 8'h05, 16'd4, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 8'h00, 16'd0, 1'b1);
        chk("t1_en_cycles", 32'(n_en), 32'd8);
        chk("t1_clr_pulses", 32'(n_clr), 32'd2);
        chk("t1_results", 32'(n_hs), 32'd2);
        chk("t1_last", 32'(n_last), 32'd1);
        chk("t1_done", 32'(n_done), 32'd1);

        // Empty mask.
        clear_counts();
        step(1'b1, 1'b0, 8'h00, 16'd4, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'h00, 16'd0, 1'b1);
        chk("t2_done", 32'(n_done), 32'd1);
        chk("t2_busy", 32'(n_busy), 32'd0);
        chk("t2_clr", 32'(n_clr), 32'd0);

        // Backpressure on the only result.
        clear_counts();
        step(1'b1, 1'b0, 8'h80, 16'd3, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 8'hFF, 16'd9, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00, 16'd0, 1'b1);
        chk("t3_clr", 32'(n_clr), 32'd1);
        chk("t3_results", 32'(n_hs), 32'd1);
        chk("t3_en_cycles", 32'(n_en), 32'd3);

        // Continuous mode with ignored starts and random ready.
        clear_counts();
        step(1'b1, 1'b1, 8'h03, 16'd2, 1'b1);
        for (int i = 0; i < 150; i++)
            step($urandom_range(0, 3) == 0, 1'($urandom), 8'($urandom), 16'($urandom_range(0, 9)),
                 $urandom_range(0, 3) != 0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 16'd0, 1'b0);
        chk("t4_done_per_pair", 32'(n_done), 32'(n_hs / 2));
        chk("t4_progress", 32'(n_hs >= 4), 32'd1);
        do_reset();

        // Reset in the middle of a long window, then a fresh sweep.
        clear_counts();
        step(1'b1, 1'b0, 8'h10, 16'd100, 1'b1);
        for (int i = 0; i < 50; i++) step(1'b0, 1'b0, 8'h00, 16'd0, 1'b1);
        chk("t5_mid_window_en", 32'(s_en), 32'h10);
        do_reset();
        clear_counts();
        step(1'b1, 1'b0, 8'h10, 16'd2, 1'b1);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 8'h00, 16'd0, 1'b1);
        chk("t5_fresh_results", 32'(n_hs), 32'd1);
        chk("t5_fresh_en", 32'(n_en), 32'd2);

        // Zero window length behaves as one cycle.
        do_reset();
        clear_counts();
        step(1'b1, 1'b0, 8'h01, 16'd0, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 8'h00, 16'd0, 1'b1);
        chk("t6_en_cycles", 32'(n_en), 32'd1);
        chk("t6_done", 32'(n_done), 32'd1);
`ifdef RO_SWEEP_ID_EN
        chk("t6_sweep_id", 32'(sweep_id), 32'd1);
`endif

        // Random sweeps with random masks, windows, ready and stray starts.
        for (int s = 0; s < 25; s++) begin
            step(1'b1, 1'b0, ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom),
                 16'($urandom_range(0, 5)), 1'($urandom));
            for (int c = 0; c < 1500; c++) begin
                if (!m_active) break;
                step($urandom_range(0, 7) == 0, 1'($urandom), 8'($urandom),
                     16'($urandom_range(0, 5)), $urandom_range(0, 3) != 0);
            end
            chk("sweep_timeout", 32'(m_active), 32'd0);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 16'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
